// File: rtl/group_uplink_arbiter.sv
// Leaf-group uplink arbiter: one flit hold per NI port, unmapped-header filter,
// round-robin grant into a registered valid/ready uplink to the group router.

module group_uplink_hold #(
  parameter int DATA_W   = 16,
  parameter int HEADER_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              grant_i,
  output logic [DATA_W-1:0] hold_data_o,
  output logic              hold_valid_o,
  output logic              drop_o
);
  logic [DATA_W-1:0] hold_q;
  logic              hold_valid_q;
  logic              accept;
  logic              mapped;

  // A grant needs a full hold and an accept needs an empty one, so they never collide.
  assign accept = in_valid_i && !hold_valid_q;
  assign mapped = |in_data_i[DATA_W-1 -: HEADER_W];
  assign drop_o = accept && !mapped;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (grant_i) begin
      hold_valid_q <= 1'b0;
    end else if (accept && mapped) begin
      hold_valid_q <= 1'b1;
      hold_q       <= in_data_i;
    end
  end

  assign hold_data_o  = hold_q;
  assign hold_valid_o = hold_valid_q;
endmodule

module group_uplink_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int HEADER_W = 6,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         up_data,
  output logic                      up_valid,
  input  logic                      up_ready,
  output logic [IDX_W-1:0]          up_src,
  output logic [CNT_W-1:0]          drop_count
);
  localparam int SUM_W = CNT_W + IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0][DATA_W-1:0] hold_data;
  logic [NUM_REQ-1:0]             hold_valid;
  logic [NUM_REQ-1:0]             drop_vec;
  logic [NUM_REQ-1:0]             grant_vec;

  logic              up_valid_q, up_valid_d;
  logic [DATA_W-1:0] up_data_q, up_data_d;
  logic [IDX_W-1:0]  up_src_q, up_src_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              slot_free;
  logic              found;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  idx;
  logic [SUM_W-1:0]  drop_sum;
  logic [SUM_W-1:0]  cnt_sum;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
    group_uplink_hold #(
      .DATA_W   (DATA_W),
      .HEADER_W (HEADER_W)
    ) u_hold (
      .clk          (clk),
      .reset        (reset),
      .in_data_i    (req_data[g*DATA_W +: DATA_W]),
      .in_valid_i   (req_valid[g]),
      .grant_i      (grant_vec[g]),
      .hold_data_o  (hold_data[g]),
      .hold_valid_o (hold_valid[g]),
      .drop_o       (drop_vec[g])
    );
  end

  assign req_ready = ~hold_valid;
  assign slot_free = !up_valid_q || up_ready;

  // Scan starts just after the last winner; index wraps naturally since NUM_REQ is 2^IDX_W.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = rr_ptr_q + k[IDX_W-1:0];
      if (!found && hold_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    grant_vec  = '0;
    up_valid_d = up_valid_q;
    up_data_d  = up_data_q;
    up_src_d   = up_src_q;
    rr_ptr_d   = rr_ptr_q;
    if (slot_free) begin
      up_valid_d = found;
      if (found) begin
        grant_vec[win] = 1'b1;
        up_data_d      = hold_data[win];
        up_src_d       = win;
        rr_ptr_d       = win;
      end
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) drop_sum = drop_sum + SUM_W'(drop_vec[i]);
    cnt_sum = SUM_W'(drop_q) + drop_sum;
    drop_d  = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_src_q   <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      drop_q     <= '0;
    end else begin
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_src_q   <= up_src_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_q     <= drop_d;
    end
  end

  assign up_valid   = up_valid_q;
  assign up_data    = up_data_q;
  assign up_src     = up_src_q;
  assign drop_count = drop_q;
endmodule
